bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential double-dabble converter that turns the unsigned multiplier product (16 bits)
//   into packed BCD digits for the 7-segment display driver.
//   Sits directly downstream of the shift-add multiplier: bin is the multiplier product bus,
//   and start is driven from the multiplier control unit's completion.
//   Uses one add-3/shift iteration per clock, with a start/busy/done handshake.
// PARAMETERS
//   WIDTH   16  binary input width; iterations per conversion = WIDTH
//   DIGITS  5   BCD digits produced; must satisfy 10**DIGITS > 2**WIDTH
// PORTS
//   clk       in   1          system clock; all logic on rising edge
//   resetCU   in   1          synchronous, active-high reset
//   start     in   1          request conversion of bin; sampled only in IDLE
//   bin       in   WIDTH      unsigned binary value (multiplier product)
//   busy      out  1          high while state != IDLE
//   done      out  1          one-cycle pulse when bcd holds the new result
//   bcd       out  4*DIGITS   packed BCD result; digit 0 (units) in [3:0]
//   digit_en  out  DIGITS     per-digit display enable (see CONFIGURATION)
// BEHAVIOUR
//   Reset (resetCU=1 at clk edge):
//     state=IDLE; busy=0; done=0; bcd=0; digit_en=all ones; counter=0; scratch cleared.
//     Reset has priority over every other input, including mid-conversion.
//     An aborted conversion produces no done and leaves bcd=0.
//   FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//     IDLE:  if start=1, latch bin into bin_sr, clear bcd_sr, load cnt=WIDTH, go to SHIFT.
//            Otherwise stay in IDLE.
//     SHIFT: each cycle, add 3 to every bcd_sr nibble >= 5 (combinational, all nibbles in parallel).
//            Then shift {bcd_sr,bin_sr} left by 1 and decrement cnt.
//            Move to DONE on the cycle in which cnt goes 1->0 (exactly WIDTH SHIFT cycles).
//     DONE:  copy bcd_sr into bcd, assert done for this cycle only, update digit_en, go to IDLE.
//   Latency: start sampled at edge N -> done=1 and new bcd visible after edge N+WIDTH+1
//     (17 cycles for WIDTH=16). Back-to-back period is WIDTH+2 cycles.
//   Handshake and output holding:
//     - start while busy=1 (SHIFT or DONE) is ignored and is not queued.
//     - start held high continuously re-triggers on each return to IDLE.
//     - bin is captured only at acceptance; later changes to bin do not affect the conversion.
//     - bcd and digit_en hold their last values between conversions.
//   Arithmetic:
//     - Every nibble of bcd always holds a value 0..9.
//     - Max input 2**WIDTH-1 (65535) converts to 0x65535, with no overflow.
//     - Add-3 is applied before the shift, never after the final shift.
// CONFIGURATION
//   Macro BCD_LEADING_ZERO_BLANK_EN:
//     Defined: digit_en[i]=0 for every leading zero digit above the most significant non-zero digit.
//       Digit 0 is always enabled, so a value of 0 shows a single "0".
//       digit_en updates in the DONE cycle together with bcd.
//     Undefined: digit_en is a constant all ones (also after reset); no blanking logic is built.
// TESTING
//   1. Reset, then bin=0, start pulse -> done after 17 cycles, bcd=20'h00000, busy low afterwards.
//   2. bin=16'd65025 (255*255) -> bcd=20'h65025; bin=16'd65535 -> bcd=20'h65535.
//   3. bin=16'd42 -> bcd=20'h00042; digit_en=5'b00011 with macro, 5'b11111 without.
//      bin=0 with macro -> digit_en=5'b00001.
//   4. start at cycle 0 with bin=100, second start at cycle 5 with bin=7
//      -> single done at cycle 17 with bcd=20'h00100; the second request is dropped.
//   5. resetCU=1 at cycle 8 of a conversion -> no done, bcd=0, busy=0 next cycle.
//      A fresh start then converts correctly.
//   6. start held high with bin changing each conversion -> done pulses every 18 cycles,
//      and each bcd matches the bin value sampled at its acceptance.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// One add-3/shift iteration per clock; WIDTH iterations per conversion.
// Optional feature macro: BCD_LEADING_ZERO_BLANK_EN (leading-zero digit blanking on digit_en).
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  resetCU,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] bin_sr;
    logic [BW-1:0]    bcd_sr;
    logic [BW-1:0]    bcd_adj;
    logic [CW-1:0]    cnt;

    // State register
    always_ff @(posedge clk) begin
        if (resetCU) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT (WIDTH cycles) -> DONE -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == CW'(1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Add 3 to every BCD nibble >= 5, all nibbles in parallel, ahead of the shift
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (resetCU) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bin_sr <= bin;
                        bcd_sr <= '0;
                        cnt    <= CW'(WIDTH);
                    end
                end
                S_SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj[BW-2:0], bin_sr, 1'b0};
                    cnt              <= cnt - CW'(1);
                end
                S_DONE: begin
                    bcd <= bcd_sr;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] en_next;
    logic              seen_nz;

    // Enable digits from the most significant non-zero digit down; units always on
    always_comb begin
        en_next = '0;
        seen_nz = 1'b0;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            if (bcd_sr[4*i +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            en_next[i] = seen_nz;
        end
        en_next[0] = 1'b1;
    end

    // Digit enables update together with bcd in the DONE cycle
    always_ff @(posedge clk) begin
        if (resetCU) begin
            digit_en <= '1;
        end else if (state == S_DONE) begin
            digit_en <= en_next;
        end
    end
`else
    assign digit_en = '1;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (WIDTH=16, DIGITS=5).
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        resetCU = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  digit_en;

    int checks = 0;
    int errors = 0;

    // 10 ns clock
    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk      (clk),
        .resetCU  (resetCU),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .digit_en (digit_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] en_exp(input logic [4:0] blank);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        return blank;
`else
        return 5'b11111;
`endif
    endfunction

    task automatic do_reset();
        resetCU = 1'b1;
        start   = 1'b0;
        bin     = '0;
        repeat (2) @(posedge clk);
        #1;
        resetCU = 1'b0;
    endtask

    // One conversion from IDLE; checks latency, result, enables and done pulse width
    task automatic run_conv(input string tag, input logic [15:0] v,
                            input logic [19:0] exp_bcd, input logic [4:0] blank);
        int lat;
        lat   = 0;
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 16'hdead;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check({tag, " busy_on"}, 32'(busy), 32'd1);
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd17);
        check({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
        check({tag, " digit_en"}, 32'(digit_en), 32'(en_exp(blank)));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        int first;
        int j;
        logic [15:0] hv [3];
        logic [19:0] hb [3];
        logic [4:0]  he [3];

        do_reset();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst bcd", 32'(bcd), 32'd0);
        check("rst digit_en", 32'(digit_en), 32'h1f);

        run_conv("zero",  16'd0,     20'h00000, 5'b00001);
        run_conv("65025", 16'd65025, 20'h65025, 5'b11111);
        run_conv("max",   16'd65535, 20'h65535, 5'b11111);
        run_conv("42",    16'd42,    20'h00042, 5'b00011);
        run_conv("one",   16'd1,     20'h00001, 5'b00001);
        run_conv("10000", 16'd10000, 20'h10000, 5'b11111);
        run_conv("zero2", 16'd0,     20'h00000, 5'b00001);

        // Second start while busy is dropped, not queued
        ndone = 0;
        first = 0;
        bin   = 16'd100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) begin
                start = 1'b1;
                bin   = 16'd7;
            end
            if (k == 5) start = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) begin
                    first = k;
                    check("drop bcd", 32'(bcd), 32'h00100);
                end
            end
        end
        check("drop first_done", 32'(first), 32'd17);
        check("drop ndone", 32'(ndone), 32'd1);

        // Reset mid-conversion aborts with no done
        ndone = 0;
        bin   = 16'd999;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 7) resetCU = 1'b1;
            if (k == 8) begin
                check("abort bcd", 32'(bcd), 32'd0);
                check("abort busy", 32'(busy), 32'd0);
                resetCU = 1'b0;
            end
            if (done) ndone++;
        end
        check("abort ndone", 32'(ndone), 32'd0);
        run_conv("after_abort", 16'd999, 20'h00999, 5'b00111);

        // start held high: re-trigger every WIDTH+2 cycles, bin captured at acceptance
        hv[0] = 16'd12345; hb[0] = 20'h12345; he[0] = 5'b11111;
        hv[1] = 16'd9999;  hb[1] = 20'h09999; he[1] = 5'b01111;
        hv[2] = 16'd50000; hb[2] = 20'h50000; he[2] = 5'b11111;
        j     = 0;
        bin   = hv[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        bin = hv[1];
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 18) bin = hv[2];
            if (k == 36) bin = 16'd4321;
            if (k == 53) start = 1'b0;
            if (done) begin
                if (j < 3) begin
                    check("held period", 32'(k), 32'(17 + 18 * j));
                    check("held bcd", 32'(bcd), 32'(hb[j]));
                    check("held digit_en", 32'(digit_en), 32'(en_exp(he[j])));
                end else begin
                    check("held extra_done", 32'(k), 32'd0);
                end
                j++;
            end
        end
        start = 1'b0;
        check("held count", 32'(j), 32'd3);
        check("held idle busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
